// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO -> start/data/parity/stop/gap framing on TXD, first start bit one cycle after a push.
// wr_ready drops when the FIFO is full; writes while full are dropped and latch overflow.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int GAP_BITS     = 0,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          TXD,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 push, pop, fifo_nonempty;
  logic [DATA_BITS-1:0] head;

  state_t               state, state_nxt;
  logic [CW-1:0]        baud_cnt, baud_nxt;
  logic [3:0]           bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 par_bit, par_nxt;
  logic                 txd_nxt, bit_end, frame_done;

  assign wr_ready      = (level != (AW+1)'(FIFO_DEPTH));
  assign push          = wr_valid & wr_ready;
  assign fifo_nonempty = (level != '0);
  assign head          = mem[rd_ptr];
  assign busy          = (state != S_IDLE) || fifo_nonempty;
  assign bit_end       = (baud_cnt == CW'(CLKS_PER_BIT-1));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (wr_valid && !wr_ready) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    baud_nxt   = bit_end ? '0 : baud_cnt + 1'b1;
    bit_nxt    = bit_cnt;
    shift_nxt  = shift;
    par_nxt    = par_bit;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        baud_nxt = '0;
        if (fifo_nonempty) begin
          pop       = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: if (bit_end) begin
        state_nxt = S_DATA;
        bit_nxt   = '0;
      end
      S_DATA: if (bit_end) begin
        shift_nxt = shift >> 1;
        if (bit_cnt == 4'(DATA_BITS-1)) begin
          bit_nxt   = '0;
          state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
        end else begin
          bit_nxt = bit_cnt + 1'b1;
        end
      end
      S_PARITY: if (bit_end) begin
        state_nxt = S_STOP;
        bit_nxt   = '0;
      end
      S_STOP: if (bit_end) begin
        if (bit_cnt == 4'(STOP_BITS-1)) begin
          bit_nxt = '0;
          if (GAP_BITS != 0) state_nxt = S_GAP;
          else               frame_done = 1'b1;
        end else begin
          bit_nxt = bit_cnt + 1'b1;
        end
      end
      S_GAP: if (bit_end) begin
        if (bit_cnt == 4'(GAP_BITS-1)) frame_done = 1'b1;
        else                           bit_nxt = bit_cnt + 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Back-to-back frames: the next word is popped on the last cycle of the frame.
    if (frame_done) begin
      bit_nxt = '0;
      if (fifo_nonempty) begin
        pop       = 1'b1;
        state_nxt = S_START;
      end else begin
        state_nxt = S_IDLE;
      end
    end
    if (pop) begin
      shift_nxt = head;
      par_nxt   = (^head) ^ (PARITY == 2);
    end
    case (state_nxt)
      S_START:  txd_nxt = 1'b0;
      S_DATA:   txd_nxt = shift_nxt[0];
      S_PARITY: txd_nxt = par_nxt;
      default:  txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      TXD      <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      par_bit  <= par_nxt;
      TXD      <= txd_nxt;
    end
  end

endmodule
